wb_cmd_master: RTL and testbench

Single-outstanding Wishbone initiator that drives the FPGA register bus as seen from the fabric side. It turns a valid/ready command stream (address, write enable, byte strobes, write data) into Wishbone classic cycles. It returns each result (read data or write completion, plus an error flag) on a valid/ready response stream. It lets fabric-side logic, such as a test sequencer or a USB command parser, exercise our register slaves, including the UART FIFO data ports, with a bus timeout to guard against a missing ACK.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_timeout_cnt.sv | 51 +++++
 rtl/wb_cmd_master.sv | 150 +++++++++++++++
 tb/tb_wb_cmd_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared state encoding and constants for the Wishbone command master
// Rev 1.0
// ============================================================================
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam logic [31:0] c_err_data = 32'hFAB_DEF_AC;
    localparam int          c_sel_w    = 4;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// wb_timeout_cnt : saturating bus-cycle counter, flags the last allowed cycle
// Rev 1.0
// ============================================================================
module wb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_last_int = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CW-1:0] c_last = CW'(c_last_int);
    localparam logic [CW-1:0] c_max  = '1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate so a stalled cycle can never wrap past the expiry point.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != c_max)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expire_o = 1'b0;
        end else begin : g_enabled
            assign expire_o = en_i && (cnt_q == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// wb_cmd_master : single-outstanding Wishbone classic initiator fed by a
//                 valid/ready command stream, with bus-timeout abort
// Rev 1.0
// ============================================================================
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int                   ADDRWIDTH      = 7,
    parameter int                   DATAWIDTH      = 32,
    parameter int                   TIMEOUT_CYCLES = 255,
    parameter logic [DATAWIDTH-1:0] ERR_DATA       = DATAWIDTH'(c_err_data)
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDRWIDTH-1:0]  cmd_adr_i,
    input  logic [c_sel_w-1:0]    cmd_sel_i,
    input  logic [DATAWIDTH-1:0]  cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATAWIDTH-1:0]  rsp_dat_o,
    output logic                  rsp_err_o,
    output logic [ADDRWIDTH-1:0]  WBm_ADR_o,
    output logic                  WBm_CYC_o,
    output logic                  WBm_STB_o,
    output logic                  WBm_WE_o,
    output logic [c_sel_w-1:0]    WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0]  WBm_DAT_o,
    input  logic [DATAWIDTH-1:0]  WBm_DAT_i,
    input  logic                  WBm_ACK_i,
    output logic                  busy_o
);

    wb_state_e              state_q, state_d;
    logic [ADDRWIDTH-1:0]   adr_q, adr_d;
    logic                   we_q, we_d;
    logic [c_sel_w-1:0]     sel_q, sel_d;
    logic [DATAWIDTH-1:0]   dat_q, dat_d;
    logic                   cyc_q, cyc_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [DATAWIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic                   w_expire;

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (WBs_CLK_i),
        .rst_i    (WBs_RST_i),
        .clear_i  (state_q == IDLE),
        .en_i     (state_q == BUS),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    adr_d   = cmd_adr_i;
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    dat_d   = cmd_dat_i;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ACK takes priority over a coincident timeout.
                if (WBm_ACK_i) begin
                    rsp_dat_d   = we_q ? '0 : WBm_DAT_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    state_d     = RESP;
                end else if (w_expire) begin
                    rsp_dat_d   = ERR_DATA;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign cmd_ready_o    = (state_q == IDLE) && !WBs_RST_i;
    assign busy_o         = (state_q != IDLE);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_dat_o      = rsp_dat_q;
    assign WBm_ADR_o      = adr_q;
    assign WBm_CYC_o      = cyc_q;
    assign WBm_STB_o      = cyc_q;
    assign WBm_WE_o       = we_q;
    assign WBm_BYTE_STB_o = sel_q;
    assign WBm_DAT_o      = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_wb_cmd_master : randomized bench for wb_cmd_master with a slave model and
//                    a transaction-level reference model
// Rev 1.0
// ============================================================================
module tb_wb_cmd_master;

    localparam int          AW       = 7;
    localparam int          DW       = 32;
    localparam int          T        = 4;
    localparam logic [31:0] ERRV     = 32'hFAB_DEF_AC;
    localparam logic [6:0]  FIFO_ADR = 7'h10;

    logic          WBs_CLK_i = 1'b0;
    logic          WBs_RST_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [AW-1:0] cmd_adr_i = '0;
    logic [3:0]    cmd_sel_i = '0;
    logic [DW-1:0] cmd_dat_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic [AW-1:0] WBm_ADR_o;
    logic          WBm_CYC_o;
    logic          WBm_STB_o;
    logic          WBm_WE_o;
    logic [3:0]    WBm_BYTE_STB_o;
    logic [DW-1:0] WBm_DAT_o;
    logic [DW-1:0] WBm_DAT_i = '0;
    logic          WBm_ACK_i = 1'b0;
    logic          busy_o;

    always #5 WBs_CLK_i = ~WBs_CLK_i;

    wb_cmd_master #(
        .ADDRWIDTH      (AW),
        .DATAWIDTH      (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .WBs_CLK_i      (WBs_CLK_i),
        .WBs_RST_i      (WBs_RST_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_adr_i      (cmd_adr_i),
        .cmd_sel_i      (cmd_sel_i),
        .cmd_dat_i      (cmd_dat_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_dat_o      (rsp_dat_o),
        .rsp_err_o      (rsp_err_o),
        .WBm_ADR_o      (WBm_ADR_o),
        .WBm_CYC_o      (WBm_CYC_o),
        .WBm_STB_o      (WBm_STB_o),
        .WBm_WE_o       (WBm_WE_o),
        .WBm_BYTE_STB_o (WBm_BYTE_STB_o),
        .WBm_DAT_o      (WBm_DAT_o),
        .WBm_DAT_i      (WBm_DAT_i),
        .WBm_ACK_i      (WBm_ACK_i),
        .busy_o         (busy_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Slave model and shared stimulus state
    int          ack_delay = 2;    // ACK in the Nth STB cycle; 0 = never
    logic        spur      = 1'b0; // ACK level driven while STB is low
    int          stb_cnt   = 0;
    int          stb_run   = 0;
    int          pops      = 0;
    int          ref_pops  = 0;
    int          edge_cnt  = 0;
    int          last_acc  = 0;
    logic        hold_ready = 1'b0;
    logic [31:0] slv_mem [128];
    logic [31:0] ref_mem [128];
    logic [6:0]  cur_adr;
    logic        cur_we;
    logic [3:0]  cur_sel;
    logic [31:0] cur_dat;

    always @(posedge WBs_CLK_i) edge_cnt <= edge_cnt + 1;

    initial begin
        for (int i = 0; i < 128; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        forever begin
            @(negedge WBs_CLK_i);
            if (WBm_CYC_o && WBm_STB_o) begin
                stb_cnt++;
                chk("wbm_fields", {WBm_ADR_o, WBm_WE_o, WBm_BYTE_STB_o, WBm_DAT_o},
                    {cur_adr, cur_we, cur_sel, cur_dat});
                if (ack_delay != 0 && stb_cnt == ack_delay) begin
                    WBm_ACK_i = 1'b1;
                    if (WBm_WE_o) begin
                        for (int b = 0; b < 4; b++)
                            if (WBm_BYTE_STB_o[b]) slv_mem[WBm_ADR_o][8*b +: 8] = WBm_DAT_o[8*b +: 8];
                        WBm_DAT_i = $urandom;
                    end else if (WBm_ADR_o == FIFO_ADR) begin
                        WBm_DAT_i = 32'h41 + 32'(pops);
                        pops++;
                    end else begin
                        WBm_DAT_i = slv_mem[WBm_ADR_o];
                    end
                end else begin
                    WBm_ACK_i = 1'b0;
                    WBm_DAT_i = $urandom;
                end
            end else begin
                if (stb_cnt != 0) begin
                    stb_run = stb_cnt;
                    stb_cnt = 0;
                end
                WBm_ACK_i = spur;
                WBm_DAT_i = $urandom;
            end
        end
    end

    // One complete command/response exchange; called just after a rising edge.
    task automatic do_txn(input logic we, input logic [6:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int d, input int r);
        logic        acked;
        int          stb_exp;
        int          lat;
        logic [31:0] exp_dat;
        logic        exp_err;
        acked   = (d >= 1) && (d <= T);
        stb_exp = acked ? d : T;
        exp_err = !acked;
        exp_dat = ERRV;
        if (acked) begin
            if (we) begin
                exp_dat = '0;
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[adr][8*b +: 8] = dat[8*b +: 8];
            end else if (adr == FIFO_ADR) begin
                exp_dat = 32'h41 + 32'(ref_pops);
                ref_pops++;
            end else begin
                exp_dat = ref_mem[adr];
            end
        end

        ack_delay = d;
        cur_adr = adr; cur_we = we; cur_sel = sel; cur_dat = dat;
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
        @(posedge WBs_CLK_i); #1;
        last_acc    = edge_cnt;
        cmd_valid_i = 1'b0;
        cmd_we_i = 1'($urandom); cmd_adr_i = 7'($urandom); cmd_sel_i = 4'($urandom); cmd_dat_i = $urandom;
        chk("bus_entry", {busy_o, cmd_ready_o, WBm_CYC_o, WBm_STB_o}, 4'b1011);

        lat = 0;
        while (!rsp_valid_o && lat < 40) begin
            @(posedge WBs_CLK_i); #1;
            lat++;
        end
        chk("rsp_latency", lat, stb_exp);
        chk("rsp_dat", rsp_dat_o, exp_dat);
        chk("rsp_err", rsp_err_o, exp_err);

        if (r > 0) begin
            rsp_ready_i = 1'b0;
            cmd_valid_i = 1'b1;
            spur        = 1'b1;
            repeat (r) begin
                @(posedge WBs_CLK_i); #1;
                chk("rsp_hold", {rsp_valid_o, cmd_ready_o, WBm_STB_o, WBm_CYC_o, rsp_err_o, rsp_dat_o},
                    {1'b1, 1'b0, 1'b0, 1'b0, exp_err, exp_dat});
            end
            cmd_valid_i = 1'b0;
            spur        = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(posedge WBs_CLK_i); #1;
        if (!hold_ready) rsp_ready_i = 1'b0;
        chk("post_handshake", {rsp_valid_o, busy_o, cmd_ready_o}, 3'b001);
        chk("stb_cycles", stb_run, stb_exp);
    endtask

    initial begin
        int acc [3];

        @(negedge WBs_CLK_i);
        chk("reset_ctrl", {WBm_CYC_o, WBm_STB_o, WBm_WE_o, rsp_valid_o, rsp_err_o, busy_o}, 6'b0);
        chk("reset_data", {WBm_ADR_o, WBm_BYTE_STB_o, WBm_DAT_o, rsp_dat_o}, 75'b0);
        @(negedge WBs_CLK_i);
        WBs_RST_i = 1'b0;
        @(posedge WBs_CLK_i); #1;
        chk("reset_release", {cmd_ready_o, rsp_valid_o, busy_o}, 3'b100);

        // Write, then read back through a registered-ACK slave
        do_txn(1'b1, 7'h02, 4'h3, 32'h0000_1234, 2, 0);
        do_txn(1'b1, 7'h00, 4'hF, 32'h0000_A5BD, 2, 0);
        do_txn(1'b0, 7'h00, 4'hF, 32'h0, 2, 0);
        chk("read_a5bd", rsp_dat_o, 32'h0000_A5BD);

        // Three back-to-back FIFO reads with the response side always ready
        hold_ready  = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b0, FIFO_ADR, 4'hF, 32'h0, 2, 0);
            acc[i] = last_acc;
        end
        hold_ready  = 1'b0;
        rsp_ready_i = 1'b0;
        chk("spacing_01", acc[1] - acc[0], 4);
        chk("spacing_12", acc[2] - acc[1], 4);
        chk("fifo_pops_3", pops, 3);

        // Timeout, ACK on the final allowed cycle, ACK just too late
        do_txn(1'b0, 7'h05, 4'hF, 32'h0, 0, 0);
        do_txn(1'b0, 7'h02, 4'hF, 32'h0, T, 0);
        do_txn(1'b1, 7'h07, 4'hF, 32'hDEAD_BEEF, T + 1, 0);

        // Spurious ACK while idle
        spur = 1'b1;
        repeat (4) begin
            @(posedge WBs_CLK_i); #1;
            chk("spur_idle", {rsp_valid_o, busy_o, cmd_ready_o}, 3'b001);
        end
        spur = 1'b0;
        @(posedge WBs_CLK_i); #1;

        // Long backpressure
        do_txn(1'b0, 7'h02, 4'hF, 32'h0, 2, 10);

        // Asynchronous reset in the middle of a bus cycle
        ack_delay = 0;
        cur_adr = 7'h03; cur_we = 1'b0; cur_sel = 4'hF; cur_dat = 32'h0;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 7'h03; cmd_sel_i = 4'hF; cmd_dat_i = 32'h0;
        @(posedge WBs_CLK_i); #1;
        cmd_valid_i = 1'b0;
        @(posedge WBs_CLK_i); #3;
        chk("pre_reset_bus", {WBm_CYC_o, WBm_STB_o}, 2'b11);
        WBs_RST_i = 1'b1;
        #1;
        chk("reset_async", {WBm_CYC_o, WBm_STB_o, busy_o, rsp_valid_o}, 4'b0);
        @(negedge WBs_CLK_i);
        WBs_RST_i = 1'b0;
        @(posedge WBs_CLK_i); #1;
        chk("reset_mid_bus_release", {cmd_ready_o, rsp_valid_o, busy_o}, 3'b100);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 4) == 0) ? FIFO_ADR : 7'($urandom_range(0, 15));
            do_txn(1'($urandom), a, 4'($urandom), $urandom,
                   int'($urandom_range(0, T + 1)), int'($urandom_range(0, 3)));
        end
        chk("fifo_pops_total", pops, ref_pops);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
